prediction_accuracy_monitor: RTL and testbench

Downstream consumer of the bimode/gshare predictor: samples each resolved branch (prediction vs. real_ton) and accumulates hit, total and mispredict-streak statistics. On request, computes the integer hit percentage with a multi-cycle restoring divider and drives porcentaje_de_aciertos. Intended for instantiation in predictor benches and for synthesizable on-chip accuracy monitoring.

---
 rtl/prediction_accuracy_monitor.sv | 153 +++++++++++++++
 tb/tb_prediction_accuracy_monitor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prediction_accuracy_monitor.sv
// Branch-prediction accuracy monitor: counts resolved branches, hits and mispredict
// streaks, and computes floor(100*hits/total) with a multi-cycle restoring divider.
module prediction_accuracy_monitor #(
    parameter int CNT_W    = 16,
    parameter int STREAK_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                br_valid,
    input  logic                prediction,
    input  logic                real_ton,
    input  logic                calc_req,
    output logic                calc_busy,
    output logic                pct_valid,
    output logic [6:0]          porcentaje_de_aciertos,
    output logic [CNT_W-1:0]    total_count,
    output logic [CNT_W-1:0]    hit_count,
    output logic [STREAK_W-1:0] miss_streak,
    output logic [STREAK_W-1:0] max_miss_streak,
    output logic                saturated
);

    localparam int NW = CNT_W + 7;
    localparam int IW = $clog2(NW);
    localparam logic [NW-1:0] HUNDRED = NW'(100);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_pct_valid;
    logic [6:0]          r_pct;
    logic [CNT_W-1:0]    r_total;
    logic [CNT_W-1:0]    r_hit;
    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] r_max;
    logic                r_sat;
    logic [NW-1:0]       r_num;
    logic [CNT_W:0]      r_rem;
    logic [CNT_W-1:0]    r_div;
    logic [IW-1:0]       r_iter;

    logic                w_hit;
    logic [CNT_W-1:0]    w_total_inc;
    logic [STREAK_W-1:0] w_streak_next;
    logic [NW-1:0]       w_num;
    logic [CNT_W+1:0]    w_rem_sh;
    logic [CNT_W:0]      w_rem_diff;
    logic                w_q_bit;
    logic [NW-1:0]       w_quot;

    assign w_hit       = (prediction == real_ton);
    assign w_total_inc = r_total + 1'b1;
    assign w_num       = NW'(r_hit) * HUNDRED;

    always_comb begin
        w_streak_next = r_streak;
        if (br_valid) begin
            if (w_hit)
                w_streak_next = '0;
            else if (r_streak != '1)
                w_streak_next = r_streak + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_total  <= '0;
            r_hit    <= '0;
            r_streak <= '0;
            r_max    <= '0;
            r_sat    <= 1'b0;
        end else begin
            if (br_valid && !r_sat) begin
                r_total <= w_total_inc;
                r_sat   <= (w_total_inc == '1);
                if (w_hit)
                    r_hit <= r_hit + 1'b1;
            end
            // Streak tracking keeps running after the total/hit counters freeze.
            r_streak <= w_streak_next;
            if (w_streak_next > r_max)
                r_max <= w_streak_next;
        end
    end

    // Numerator doubles as the quotient register: one quotient bit shifts in per step.
    assign w_rem_sh   = {r_rem, r_num[NW-1]};
    assign w_q_bit    = (w_rem_sh >= {2'b00, r_div});
    assign w_rem_diff = w_rem_sh[CNT_W:0] - {1'b0, r_div};
    assign w_quot     = {r_num[NW-2:0], w_q_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_pct_valid <= 1'b0;
            r_pct       <= '0;
            r_num       <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_iter      <= '0;
        end else begin
            r_pct_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (calc_req) begin
                        r_busy <= 1'b1;
                        if (r_total == '0) begin
                            r_state     <= S_DONE;
                            r_pct       <= '0;
                            r_pct_valid <= 1'b1;
                        end else begin
                            r_state <= S_DIV;
                            r_num   <= w_num;
                            r_div   <= r_total;
                            r_rem   <= '0;
                            r_iter  <= '0;
                        end
                    end
                end
                S_DIV: begin
                    r_num  <= w_quot;
                    r_rem  <= w_q_bit ? w_rem_diff : w_rem_sh[CNT_W:0];
                    r_iter <= r_iter + 1'b1;
                    if (r_iter == IW'(NW - 1)) begin
                        r_state     <= S_DONE;
                        r_pct       <= w_quot[6:0];
                        r_pct_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign calc_busy              = r_busy;
    assign pct_valid              = r_pct_valid;
    assign porcentaje_de_aciertos = r_pct;
    assign total_count            = r_total;
    assign hit_count              = r_hit;
    assign miss_streak            = r_streak;
    assign max_miss_streak        = r_max;
    assign saturated              = r_sat;

endmodule

// File: tb/tb_prediction_accuracy_monitor.sv
// Bench for prediction_accuracy_monitor: vector table, directed corner sequences and
// randomized traffic against an arithmetic reference model.
module tb_prediction_accuracy_monitor;

    localparam int CW   = 16;
    localparam int SW   = 8;
    localparam int NLAT = CW + 7;

    logic clk = 1'b0;
    logic rst, br_valid, prediction, real_ton, calc_req;

    logic          calc_busy, pct_valid, saturated;
    logic [6:0]    pct;
    logic [CW-1:0] total_count, hit_count;
    logic [SW-1:0] miss_streak, max_miss_streak;

    logic          s_busy, s_valid, s_sat;
    logic [6:0]    s_pct;
    logic [CW-1:0] s_total, s_hit;
    logic [1:0]    s_streak, s_max;

    logic          c_busy, c_valid, c_sat;
    logic [6:0]    c_pct;
    logic [3:0]    c_total, c_hit;
    logic [7:0]    c_streak, c_max;

    prediction_accuracy_monitor #(.CNT_W(CW), .STREAK_W(SW)) dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .prediction(prediction),
        .real_ton(real_ton), .calc_req(calc_req), .calc_busy(calc_busy),
        .pct_valid(pct_valid), .porcentaje_de_aciertos(pct),
        .total_count(total_count), .hit_count(hit_count), .miss_streak(miss_streak),
        .max_miss_streak(max_miss_streak), .saturated(saturated));

    prediction_accuracy_monitor #(.CNT_W(16), .STREAK_W(2)) dut_s (
        .clk(clk), .rst(rst), .br_valid(br_valid), .prediction(prediction),
        .real_ton(real_ton), .calc_req(calc_req), .calc_busy(s_busy),
        .pct_valid(s_valid), .porcentaje_de_aciertos(s_pct),
        .total_count(s_total), .hit_count(s_hit), .miss_streak(s_streak),
        .max_miss_streak(s_max), .saturated(s_sat));

    prediction_accuracy_monitor #(.CNT_W(4), .STREAK_W(8)) dut_c (
        .clk(clk), .rst(rst), .br_valid(br_valid), .prediction(prediction),
        .real_ton(real_ton), .calc_req(calc_req), .calc_busy(c_busy),
        .pct_valid(c_valid), .porcentaje_de_aciertos(c_pct),
        .total_count(c_total), .hit_count(c_hit), .miss_streak(c_streak),
        .max_miss_streak(c_max), .saturated(c_sat));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    typedef struct {
        logic v; logic p; logic r;
        int tot; int hit; int s; int m;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic drive(input logic v, input logic p, input logic r, input logic c);
        br_valid = v; prediction = p; real_ton = r; calc_req = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic branch(input logic p, input logic r);
        drive(1, p, r, 0);
        tick();
        drive(0, 0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},  calc_busy, 0);
        chk({tag, "_valid"}, pct_valid, 0);
        chk({tag, "_pct"},   pct, 0);
        chk({tag, "_total"}, total_count, 0);
        chk({tag, "_hit"},   hit_count, 0);
        chk({tag, "_streak"}, miss_streak, 0);
        chk({tag, "_max"},   max_miss_streak, 0);
        chk({tag, "_sat"},   saturated, 0);
    endtask

    task automatic run_pct(input string tag, input int exp_val, input int exp_lat);
        int n;
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        n = 0;
        while (!pct_valid && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_value"}, pct, exp_val);
        chk({tag, "_busy_done"}, calc_busy, 1);
        tick();
        chk({tag, "_pulse_end"}, pct_valid, 0);
        chk({tag, "_busy_end"}, calc_busy, 0);
        chk({tag, "_hold"}, pct, exp_val);
    endtask

    // Reference model state for randomized traffic.
    int m_tot, m_hit, m_s, m_m, m_sat, m_acc, m_done, m_res, m_pct;

    initial begin
        int n, seen;
        rst = 1'b1;
        drive(0, 0, 0, 0);

        tbl[0] = '{1'b1, 1'b1, 1'b0, 1, 0, 1, 1};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 2, 0, 2, 2};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 3, 0, 3, 3};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 4, 1, 0, 3};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 5, 1, 1, 3};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 5, 1, 1, 3};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 6, 2, 0, 3};

        // Reset, then a request with nothing counted.
        do_reset();
        check_zero("reset");
        run_pct("zero_total", 0, 0);

        // Vector table: streak pattern miss,miss,miss,hit,miss plus idle and hit cycles.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].v, tbl[i].p, tbl[i].r, 0);
            tick();
            chk($sformatf("tbl%0d_total", i), total_count, tbl[i].tot);
            chk($sformatf("tbl%0d_hit", i), hit_count, tbl[i].hit);
            chk($sformatf("tbl%0d_streak", i), miss_streak, tbl[i].s);
            chk($sformatf("tbl%0d_max", i), max_miss_streak, tbl[i].m);
        end
        drive(0, 0, 0, 0);

        // Percentages: 3/4, 2/3, 7/7.
        do_reset();
        branch(1, 1); branch(0, 0); branch(1, 0); branch(0, 0);
        chk("p75_total", total_count, 4);
        chk("p75_hit", hit_count, 3);
        run_pct("p75", 75, NLAT);
        do_reset();
        branch(1, 1); branch(0, 1); branch(1, 1);
        run_pct("p66", 66, NLAT);
        do_reset();
        for (int i = 0; i < 7; i++) branch(i[0], i[0]);
        run_pct("p100", 100, NLAT);

        // Streak saturation with STREAK_W=2.
        do_reset();
        for (int i = 0; i < 5; i++) branch(1, 0);
        chk("sw2_streak", s_streak, 3);
        chk("sw2_max", s_max, 3);
        chk("sw8_streak", miss_streak, 5);
        branch(1, 1);
        chk("sw2_streak_clr", s_streak, 0);
        chk("sw2_max_hold", s_max, 3);

        // Counter saturation with CNT_W=4.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            branch(1, 1);
            if (i == 13) begin
                chk("c4_total14", c_total, 14);
                chk("c4_sat14", c_sat, 0);
            end
        end
        chk("c4_total", c_total, 15);
        chk("c4_hit", c_hit, 15);
        chk("c4_sat", c_sat, 1);
        chk("c16_total", total_count, 20);
        chk("c16_sat", saturated, 0);

        // Request while busy plus branches during DIV: snapshot 2/4 -> 50.
        do_reset();
        branch(1, 1); branch(0, 0); branch(1, 0); branch(0, 1);
        drive(0, 0, 0, 1);
        tick();
        chk("busy_after_req", calc_busy, 1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 1);
            tick();
            n++;
        end
        drive(0, 0, 0, 0);
        while (!pct_valid && n < 60) begin
            tick();
            n++;
        end
        chk("busy_latency", n, NLAT);
        chk("busy_value", pct, 50);
        chk("busy_total", total_count, 9);
        chk("busy_hit", hit_count, 2);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (pct_valid || calc_busy) seen++;
        end
        chk("busy_req_not_queued", seen, 0);

        // Reset mid-DIV aborts the computation.
        branch(1, 1);
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("middiv_busy_before", calc_busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("middiv");
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (pct_valid) seen++;
        end
        chk("middiv_no_pulse", seen, 0);
        branch(1, 1); branch(0, 0); branch(0, 1);
        run_pct("middiv_after", 66, NLAT);

        // Randomized traffic against the reference model.
        do_reset();
        m_tot = 0; m_hit = 0; m_s = 0; m_m = 0; m_sat = 0;
        m_acc = edge_n - 10; m_done = edge_n - 10; m_res = 0; m_pct = 0;
        for (int i = 0; i < 2500; i++) begin
            logic v, p, r, c;
            v = ($urandom_range(0, 3) != 0);
            p = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) == 0) ? ~p : p;
            c = ($urandom_range(0, 19) == 0);
            drive(v, p, r, c);
            tick();
            if (c && edge_n > m_done + 1) begin
                m_acc  = edge_n;
                m_done = edge_n + ((m_tot == 0) ? 0 : NLAT);
                m_res  = (m_tot == 0) ? 0 : (m_hit * 100) / m_tot;
            end
            if (v) begin
                if (m_sat == 0) begin
                    m_tot++;
                    if (p == r) m_hit++;
                    if (m_tot == (1 << CW) - 1) m_sat = 1;
                end
                m_s = (p == r) ? 0 : ((m_s < (1 << SW) - 1) ? m_s + 1 : m_s);
                if (m_s > m_m) m_m = m_s;
            end
            if (edge_n == m_done) m_pct = m_res;
            chk("rnd_total", total_count, m_tot);
            chk("rnd_hit", hit_count, m_hit);
            chk("rnd_streak", miss_streak, m_s);
            chk("rnd_max", max_miss_streak, m_m);
            chk("rnd_sat", saturated, m_sat);
            chk("rnd_valid", pct_valid, (edge_n == m_done) ? 1 : 0);
            chk("rnd_busy", calc_busy, (edge_n >= m_acc && edge_n <= m_done) ? 1 : 0);
            chk("rnd_pct", pct, m_pct);
        end
        drive(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
